scalar_mul_sched: RTL and testbench
===================================

# scalar_mul_sched

Sequencer for the Ed25519 scalar-multiplication datapath. It recodes a 255-bit scalar into width-W NAF digits, then issues a stream of point-operation commands (table precompute, load, double, add) to the point-arithmetic unit over a valid/ready handshake. It signals completion once the unit has drained the last command. It owns no field arithmetic.

## Interface
- W, 4: wNAF window width (2..6); table holds 2^(W-2) odd multiples P,3P,…
- NBITS, 255: scalar width
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle start; sampled only in IDLE
- i_M  in  NBITS  scalar, captured on accepted i_start
- o_busy  out  1  high from accepted start until o_finished cycle inclusive
- o_cmd_valid  out  1  command present
- i_cmd_ready  in  1  datapath can accept; high also means datapath idle
- o_cmd_op  out  3  0 LOAD acc=±T[idx], 1 DBL acc=2acc, 2 ADD acc+=±T[idx], 3 PRE T[idx]=T[idx-1]+2P, 4 IDENT acc=O
- o_cmd_idx  out  W-2 (min 1)  table index
- o_cmd_neg  out  1  negate table point
- o_cmd_dummy  out  1  ADD result to be discarded
- o_finished  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RECODE, PRE, EVAL, DRAIN.
- IDLE: i_start → load k (NBITS+1 bits) = i_M, digit count L=0 → RECODE. i_start in any other state ignored.
- RECODE, one digit per cycle: if k odd, d = k mod 2^W, minus 2^W if d ≥ 2^(W-1); else d=0. Store d (W-bit signed) at buffer[L]; k = (k−d)>>1; L++. Leave when k==0 after update, or immediately if k==0 on entry (M=0).
- Buffer depth NBITS+1; L ≤ NBITS+1; top digit nonzero.
- M=0: skip PRE, issue single IDENT, → DRAIN.
- PRE: issue PRE idx=1..2^(W-2)−1 in order; none if W=2.
- EVAL: first command LOAD from top digit buffer[L−1]; then for i=L−2 down to 0: DBL, then ADD if d_i≠0.
- LOAD/ADD: idx=(|d|−1)>>1, neg=(d<0).
- After last command transfer → DRAIN; when i_cmd_ready=1 in DRAIN, pulse o_finished, → IDLE.
- Command transfer = o_cmd_valid & i_cmd_ready. Op/idx/neg/dummy held stable while valid & !ready. Next command presented cycle after transfer; no bubbles beyond that.

## Timing
- Reset: state IDLE; o_busy, o_cmd_valid, o_cmd_neg, o_cmd_dummy, o_finished = 0; o_cmd_op=0, o_cmd_idx=0. Buffer contents not cleared.
- Start accepted cycle 0; o_busy=1 from cycle 1; RECODE occupies cycles 1..L (one cycle for M=0).
- First o_cmd_valid at cycle L+1; back-to-back transfers with ready held high.
- o_finished ≥1 cycle after last transfer; o_busy drops cycle after o_finished.
- Reset mid-operation: immediate return to reset values; in-flight command abandoned, no o_finished.
- i_start coincident with o_finished: ignored (state not yet IDLE).

## Configuration
- SCALAR_MUL_DUMMY_ADD_EN defined: in EVAL every zero digit (i<L−1) is followed after its DBL by ADD idx=0, neg=0, o_cmd_dummy=1. Command count depends only on L (side-channel hardening).
- Undefined: zero digits issue only DBL; o_cmd_dummy tied 0.

## Test plan
- W=4, M=0 → IDENT only, no PRE; o_finished after datapath ready.
- W=4, M=1 → PRE 1,2,3; LOAD idx0 +; finish. M=7 → PRE×3; LOAD idx3 +.
- W=4, M=15 → digits d4=+1, d0=−1 (L=5, first valid at cycle 6); PRE×3, LOAD 0 +, DBL×4, ADD idx0 neg.
- M=259f4329e6f4590b9a164106cf6a659eb4862b21fb97d43588561712e8e5216a, random ready backpressure → stream replayed in scalar golden model evaluates to M; held fields stable under stall; P=(0fa4d2a9…2fae, 2f0fe267…bea2) through ScalarMul gives x=16577cc5…c1c7, y=6d902893…b800, z=78dad67d…7f3e.
- Reset asserted mid-EVAL with valid pending → all outputs at reset values next edge; new start then completes M=15 correctly.
- SCALAR_MUL_DUMMY_ADD_EN, M=15 → extra ADD idx0 dummy=1 after DBLs 1–3; ADD/DBL count independent of M for equal L.

Source files
------------

// File: rtl/scalar_mul_sched_if.sv
// Command channel between the scalar-multiplication sequencer (master) and the
// point-arithmetic unit (slave).
interface scalar_mul_sched_if #(
  parameter int W = 4
);
  localparam int IW = (W > 2) ? W - 2 : 1;

  logic          o_cmd_valid;
  logic          i_cmd_ready;
  logic [2:0]    o_cmd_op;
  logic [IW-1:0] o_cmd_idx;
  logic          o_cmd_neg;
  logic          o_cmd_dummy;

  modport master (
    output o_cmd_valid, o_cmd_op, o_cmd_idx, o_cmd_neg, o_cmd_dummy,
    input  i_cmd_ready
  );

  modport slave (
    input  o_cmd_valid, o_cmd_op, o_cmd_idx, o_cmd_neg, o_cmd_dummy,
    output i_cmd_ready
  );
endinterface

// File: rtl/scalar_mul_sched.sv
// Ed25519 scalar-multiplication sequencer: wNAF recoding, then a LOAD/DBL/ADD command stream.
// Define SCALAR_MUL_DUMMY_ADD_EN to pad zero digits with dummy ADDs (constant command count per L).
module scalar_mul_sched #(
  parameter int W     = 4,
  parameter int NBITS = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NBITS-1:0]   i_M,
  output logic               o_busy,
  output logic               o_finished,
  scalar_mul_sched_if.master cmd
);
  localparam int IW    = (W > 2) ? W - 2 : 1;
  localparam int KW    = NBITS + 1;
  localparam int DEPTH = NBITS + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] PreLast = IW'((1 << (W - 2)) - 1);
`ifdef SCALAR_MUL_DUMMY_ADD_EN
  localparam bit DummyEn = 1'b1;
`else
  localparam bit DummyEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_DBL   = 3'd1,
    OP_ADD   = 3'd2,
    OP_PRE   = 3'd3,
    OP_IDENT = 3'd4
  } op_e;

  typedef enum logic [2:0] {S_IDLE, S_RECODE, S_PRE, S_EVAL, S_DRAIN} state_e;

  state_e              state_q;
  logic [KW-1:0]       k_q;
  logic [LW-1:0]       len_q;
  logic [LW-1:0]       rem_q;
  logic                busy_q;
  logic                fin_q;
  logic                valid_q;
  op_e                 op_q;
  logic [IW-1:0]       idx_q;
  logic                neg_q;
  logic                dummy_q;
  logic signed [W-1:0] dbuf [DEPTH];

  logic signed [W-1:0] rc_d;
  logic [KW-1:0]       rc_k_d;
  logic signed [W-1:0] top_d;
  logic signed [W-1:0] cur_d;
  logic [LW-1:0]       rem_left;
  logic                xfer;

  function automatic logic [IW-1:0] digit_idx(input logic signed [W-1:0] d);
    logic [W-1:0] mag;
    mag = d[W-1] ? -d : d;
    return IW'((mag - W'(1)) >> 1);
  endfunction

  // The low W bits read as two's complement are exactly the centred odd residue.
  always_comb begin
    rc_d     = k_q[0] ? k_q[W-1:0] : '0;
    rc_k_d   = (k_q - {{(KW - W){rc_d[W-1]}}, rc_d}) >> 1;
    top_d    = dbuf[AW'(len_q - LW'(1))];
    cur_d    = dbuf[AW'(rem_q - LW'(1))];
    rem_left = (op_q == OP_ADD) ? rem_q - LW'(1) : rem_q;
    xfer     = valid_q & cmd.i_cmd_ready;
  end

  always_ff @(posedge i_clk) begin
    if (state_q == S_RECODE && k_q != '0) begin
      dbuf[AW'(len_q)] <= rc_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      valid_q <= 1'b0;
      op_q    <= OP_LOAD;
      idx_q   <= '0;
      neg_q   <= 1'b0;
      dummy_q <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            k_q     <= {1'b0, i_M};
            len_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RECODE;
          end
        end
        S_RECODE: begin
          if (k_q == '0) begin
            valid_q <= 1'b1;
            op_q    <= OP_IDENT;
            idx_q   <= '0;
            neg_q   <= 1'b0;
            dummy_q <= 1'b0;
            state_q <= S_EVAL;
          end else begin
            k_q   <= rc_k_d;
            len_q <= len_q + LW'(1);
            if (rc_k_d == '0) begin
              valid_q <= 1'b1;
              dummy_q <= 1'b0;
              // The digit just produced is the top digit; feed it straight to LOAD when no table exists.
              if (W > 2) begin
                op_q    <= OP_PRE;
                idx_q   <= IW'(1);
                neg_q   <= 1'b0;
                state_q <= S_PRE;
              end else begin
                op_q    <= OP_LOAD;
                idx_q   <= digit_idx(rc_d);
                neg_q   <= rc_d[W-1];
                rem_q   <= len_q;
                state_q <= S_EVAL;
              end
            end
          end
        end
        S_PRE: begin
          if (xfer) begin
            if (idx_q == PreLast) begin
              op_q    <= OP_LOAD;
              idx_q   <= digit_idx(top_d);
              neg_q   <= top_d[W-1];
              rem_q   <= len_q - LW'(1);
              state_q <= S_EVAL;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        S_EVAL: begin
          if (xfer) begin
            // rem_q counts digits still to consume; cur_d is the one under the pending DBL.
            case (op_q)
              OP_DBL: begin
                if (cur_d != '0 || DummyEn) begin
                  op_q    <= OP_ADD;
                  idx_q   <= (cur_d != '0) ? digit_idx(cur_d) : '0;
                  neg_q   <= cur_d[W-1];
                  dummy_q <= (cur_d == '0);
                end else begin
                  rem_q <= rem_q - LW'(1);
                  if (rem_q == LW'(1)) begin
                    valid_q <= 1'b0;
                    state_q <= S_DRAIN;
                  end
                end
              end
              OP_LOAD, OP_ADD: begin
                rem_q <= rem_left;
                if (rem_left == '0) begin
                  valid_q <= 1'b0;
                  state_q <= S_DRAIN;
                end else begin
                  op_q    <= OP_DBL;
                  idx_q   <= '0;
                  neg_q   <= 1'b0;
                  dummy_q <= 1'b0;
                end
              end
              default: begin
                valid_q <= 1'b0;
                state_q <= S_DRAIN;
              end
            endcase
          end
        end
        S_DRAIN: begin
          if (fin_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cmd.i_cmd_ready) begin
            fin_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy          = busy_q;
  assign o_finished      = fin_q;
  assign cmd.o_cmd_valid = valid_q;
  assign cmd.o_cmd_op    = op_q;
  assign cmd.o_cmd_idx   = idx_q;
  assign cmd.o_cmd_neg   = neg_q;
  assign cmd.o_cmd_dummy = dummy_q;
endmodule

// File: tb/tb_scalar_mul_sched.sv
// Scoreboard bench for scalar_mul_sched (W=4): directed command streams plus a
// scalar replay of a full 255-bit multiplication under random backpressure.
module tb_scalar_mul_sched;
  localparam int W     = 4;
  localparam int NBITS = 255;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] idx;
    logic       neg;
    logic       dummy;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NBITS-1:0] m_in;
  logic             busy;
  logic             finished;

  scalar_mul_sched_if #(.W(W)) cif ();

  scalar_mul_sched #(.W(W), .NBITS(NBITS)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_M        (m_in),
    .o_busy     (busy),
    .o_finished (finished),
    .cmd        (cif)
  );

  always #5 clk = ~clk;

  cmd_t               exp_q[$];
  int                 checks = 0;
  int                 errors = 0;
  bit                 replay = 1'b0;
  bit                 rand_ready = 1'b0;
  bit                 stall_prev = 1'b0;
  cmd_t               held;
  logic signed [263:0] acc;
  int                 pre_cnt = 0;
  int                 add_cnt = 0;
  int                 dbl_cnt = 0;

  task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cmd_t cur_cmd();
    cmd_t c;
    c.op    = cif.o_cmd_op;
    c.idx   = cif.o_cmd_idx;
    c.neg   = cif.o_cmd_neg;
    c.dummy = cif.o_cmd_dummy;
    return c;
  endfunction

  // Monitor: compare every transfer against the scoreboard (or replay it), and
  // verify that a stalled command is held unchanged.
  always @(negedge clk) begin
    cmd_t c;
    logic signed [263:0] tv;
    c = cur_cmd();
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", cif.o_cmd_valid, 1);
        check("stall_fields_held", c, held);
      end
      if (cif.o_cmd_valid && cif.i_cmd_ready) begin
        if (c.op == 3'd1) dbl_cnt++;
        if (c.op == 3'd2) add_cnt++;
        if (c.op == 3'd3) pre_cnt++;
        if (replay) begin
          tv = 264'(c.idx) * 2 + 1;
          case (c.op)
            3'd0: acc = c.neg ? -tv : tv;
            3'd1: acc = acc * 2;
            3'd2: if (!c.dummy) acc = c.neg ? acc - tv : acc + tv;
            3'd4: acc = '0;
            default: ;
          endcase
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got %0h expected none", c);
        end else begin
          check("cmd_stream", c, exp_q.pop_front());
        end
      end
      stall_prev = cif.o_cmd_valid && !cif.i_cmd_ready;
      held = c;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 cif.i_cmd_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int op, input int idx, input bit neg, input bit dmy);
    cmd_t c;
    c.op    = 3'(op);
    c.idx   = 2'(idx);
    c.neg   = neg;
    c.dummy = dmy;
    exp_q.push_back(c);
  endtask

  task automatic push_pre();
    for (int i = 1; i <= 3; i++) push(3, i, 0, 0);
  endtask

  task automatic do_start(input logic [NBITS-1:0] m);
    add_cnt = 0;
    dbl_cnt = 0;
    pre_cnt = 0;
    m_in  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_cycle1", busy, 1);
  endtask

  task automatic wait_valid(input int exp_cycle);
    int c = 1;
    while (!cif.o_cmd_valid && c < 400) begin
      tick();
      c++;
    end
    check("first_valid_cycle", c, exp_cycle);
  endtask

  // Waits for o_finished, then offers i_start in that same cycle: it must be ignored.
  task automatic wait_finish();
    int c = 0;
    while (!finished && c < 20000) begin
      tick();
      c++;
    end
    check("finished_seen", finished, 1);
    check("busy_at_finish", busy, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("finished_one_cycle", finished, 0);
    check("busy_after_finish", busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    tick();
    check("idle_no_restart", {busy, cif.o_cmd_valid}, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, cif.o_cmd_valid, 0);
    check({tag, "_finished"}, finished, 0);
    check({tag, "_op"}, cif.o_cmd_op, 0);
    check({tag, "_idx"}, cif.o_cmd_idx, 0);
    check({tag, "_neg"}, cif.o_cmd_neg, 0);
    check({tag, "_dummy"}, cif.o_cmd_dummy, 0);
  endtask

  // M=15: digits d4=+1, d0=-1, L=5.
  task automatic push_m15();
    push_pre();
    push(0, 0, 0, 0);
`ifdef SCALAR_MUL_DUMMY_ADD_EN
    for (int i = 0; i < 3; i++) begin
      push(1, 0, 0, 0);
      push(2, 0, 0, 1);
    end
`else
    for (int i = 0; i < 3; i++) push(1, 0, 0, 0);
`endif
    push(1, 0, 0, 0);
    push(2, 0, 1, 0);
  endtask

  logic [255:0] bigm;
  int           add15;
  int           dbl15;

  initial begin
    bigm  = 256'h259f4329e6f4590b9a164106cf6a659eb4862b21fb97d43588561712e8e5216a;
    rst   = 1'b1;
    start = 1'b0;
    m_in  = '0;
    cif.i_cmd_ready = 1'b1;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    check_reset_vals("post_reset");

    // M=0: single IDENT, completion waits on datapath ready.
    cif.i_cmd_ready = 1'b0;
    push(4, 0, 0, 0);
    do_start('0);
    for (int i = 0; i < 6; i++) tick();
    check("m0_ident_pending", cif.o_cmd_valid, 1);
    check("m0_no_finish_while_busy", finished, 0);
    cif.i_cmd_ready = 1'b1;
    wait_finish();

    // M=1 and M=7: single digit, L=1.
    push_pre();
    push(0, 0, 0, 0);
    do_start(255'd1);
    wait_valid(2);
    wait_finish();

    push_pre();
    push(0, 3, 0, 0);
    do_start(255'd7);
    wait_valid(2);
    wait_finish();

    push_m15();
    do_start(255'd15);
    wait_valid(6);
    wait_finish();
    add15 = add_cnt;
    dbl15 = dbl_cnt;
    check("m15_dbl_count", dbl15, 4);

    // M=17: digits d4=+1, d0=+1, same L as 15.
    push_pre();
    push(0, 0, 0, 0);
`ifdef SCALAR_MUL_DUMMY_ADD_EN
    for (int i = 0; i < 3; i++) begin
      push(1, 0, 0, 0);
      push(2, 0, 0, 1);
    end
`else
    for (int i = 0; i < 3; i++) push(1, 0, 0, 0);
`endif
    push(1, 0, 0, 0);
    push(2, 0, 0, 0);
    do_start(255'd17);
    wait_valid(6);
    wait_finish();
`ifdef SCALAR_MUL_DUMMY_ADD_EN
    check("dummy_add_count_equal_L", add_cnt, add15);
`endif

    // Full-width scalar with random backpressure, checked by scalar replay.
    replay = 1'b1;
    acc    = '0;
    rand_ready = 1'b1;
    do_start(bigm[NBITS-1:0]);
    wait_finish();
    rand_ready = 1'b0;
    tick();
    cif.i_cmd_ready = 1'b1;
    replay = 1'b0;
    check("replay_equals_M", acc, {8'h00, bigm});
    check("replay_pre_count", pre_cnt, 3);

    // Reset with a DBL pending in EVAL.
    push_pre();
    push(0, 0, 0, 0);
    do_start(255'd15);
    begin
      int c = 0;
      while (!(cif.o_cmd_valid && cif.o_cmd_op == 3'd1) && c < 100) begin
        tick();
        c++;
      end
    end
    cif.i_cmd_ready = 1'b0;
    check("midrun_dbl_pending", {cif.o_cmd_valid, cif.o_cmd_op}, {1'b1, 3'd1});
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    exp_q.delete();
    tick();
    check_reset_vals("reset_held");
    rst = 1'b0;
    cif.i_cmd_ready = 1'b1;
    tick();
    check("no_finish_after_reset", finished, 0);
    push_m15();
    do_start(255'd15);
    wait_valid(6);
    wait_finish();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
